// File: rtl/lfsr_rand_pkg.sv
// lfsr_rand_pkg: shared FSM state type and default XNOR tap masks for lfsr_rand
package lfsr_rand_pkg;
  typedef enum logic {IDLE, GEN} fsm_e;
  localparam logic [7:0]  TAPS_8  = 8'h88;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: XNOR Fibonacci LFSR register with seed load and optional lock-up recovery
// Ports: clk, reset (sync, active-high), step, seed_load, seed[WIDTH] in;
//        state_d (value the register takes at the next edge), state_q out.
// Macro LFSR_RAND_LOCKUP_RECOVER_EN: an all-ones state is replaced by 0 at the next edge.
module lfsr_core #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'h88
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state_d,
  output logic [WIDTH-1:0] state_q
);
  logic fb;
  always_comb begin
    fb = ~^(state_q & TAPS);
    state_d = seed_load ? seed : step ? {state_q[WIDTH-2:0], fb} : state_q;
`ifdef LFSR_RAND_LOCKUP_RECOVER_EN
    if (!seed_load && &state_q) state_d = '0;
`endif
  end
  always_ff @(posedge clk) state_q <= reset ? '0 : state_d;
endmodule

// File: rtl/lfsr_rand.sv
// lfsr_rand: bounded random value generator using LFSR rejection sampling
// Ports: clk, reset (sync, active-high), enable, seed_load, seed[WIDTH], req, limit[OUT_W] in;
//        busy, valid, value[OUT_W], state_out[WIDTH] out.
// Macro LFSR_RAND_LOCKUP_RECOVER_EN enables all-ones lock-up recovery in lfsr_core.
module lfsr_rand
  import lfsr_rand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = TAPS_8,
  parameter int OUT_W = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic [WIDTH-1:0] state_out
);
  fsm_e fsm_q, fsm_d;
  logic [OUT_W-1:0] limit_q, limit_d, value_q, value_d, cand;
  logic [7:0] tries_q, tries_d;
  logic valid_q, valid_d;
  logic [WIDTH-1:0] next_state;
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk(clk),
    .reset(reset),
    .step(fsm_q == GEN || enable),
    .seed_load(seed_load),
    .seed(seed),
    .state_d(next_state),
    .state_q(state_out)
  );
  always_comb begin
    fsm_d = fsm_q;
    limit_d = limit_q;
    tries_d = tries_q;
    value_d = value_q;
    valid_d = 1'b0;
    cand = next_state[OUT_W-1:0];
    if (seed_load) fsm_d = IDLE;
    else if (fsm_q == IDLE) begin
      if (req) begin
        limit_d = limit;
        tries_d = '0;
        fsm_d = GEN;
      end
    end else if (limit_q == '0 || cand < limit_q || tries_q == 8'(MAX_TRIES - 1)) begin
      // limit 0 yields 0; an exhausted try budget falls back to limit-1
      value_d = limit_q == '0 ? '0 : cand < limit_q ? cand : limit_q - 1'b1;
      valid_d = 1'b1;
      fsm_d = IDLE;
    end else tries_d = tries_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= IDLE;
      limit_q <= '0;
      tries_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      limit_q <= limit_d;
      tries_q <= tries_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end
  assign busy = fsm_q == GEN;
  assign valid = valid_q;
  assign value = value_q;
endmodule

// File: tb/tb_lfsr_rand.sv
// tb_lfsr_rand: directed self-checking bench for lfsr_rand with default parameters
module tb_lfsr_rand;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, seed_load = 1'b0, req = 1'b0;
  logic [7:0] seed = '0, limit = '0, value, state_out;
  logic busy, valid;
  int vectors = 0, miscompares = 0;
  logic [7:0] fr [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
  always #5 clk = ~clk;
  lfsr_rand dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .req(req), .limit(limit), .busy(busy), .valid(valid), .value(value), .state_out(state_out)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_state", state_out, 8'h00);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_value", value, 8'h00);
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("free_run%0d", i), state_out, fr[i]);
    end
    enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    limit = 8'd4;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("acc_busy", 8'(busy), 8'd1);
    chk("acc_valid_early", 8'(valid), 8'd0);
    tick();
    chk("acc_valid", 8'(valid), 8'd1);
    chk("acc_value", value, 8'h01);
    chk("acc_busy_done", 8'(busy), 8'd0);
    tick();
    chk("acc_valid_pulse", 8'(valid), 8'd0);
    chk("acc_value_hold", value, 8'h01);
    limit = 8'd0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("lim0_valid", 8'(valid), 8'd1);
    chk("lim0_value", value, 8'h00);
    chk("lim0_state", state_out, 8'h03);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    limit = 8'd1;
    req = 1'b1;
    tick();
    req = 1'b0;
    limit = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fb_wait_valid%0d", i), 8'(valid), 8'd0);
      chk($sformatf("fb_wait_busy%0d", i), 8'(busy), 8'd1);
    end
    tick();
    chk("fb_valid", 8'(valid), 8'd1);
    chk("fb_value", value, 8'h00);
    chk("fb_state", state_out, 8'h0F);
    chk("fb_busy", 8'(busy), 8'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    limit = 8'd4;
    req = 1'b1;
    tick();
    req = 1'b0;
    seed_load = 1'b1;
    seed = 8'h5A;
    tick();
    seed_load = 1'b0;
    chk("abort_valid", 8'(valid), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_state", state_out, 8'h5A);
    tick();
    chk("abort_valid_after", 8'(valid), 8'd0);
    chk("abort_state_hold", state_out, 8'h5A);
    seed_load = 1'b1;
    seed = 8'hFF;
    tick();
    seed_load = 1'b0;
    chk("lock_load", state_out, 8'hFF);
    enable = 1'b1;
    tick();
`ifdef LFSR_RAND_LOCKUP_RECOVER_EN
    chk("lock_step1", state_out, 8'h00);
    tick();
    chk("lock_step2", state_out, 8'h01);
`else
    chk("lock_step1", state_out, 8'hFF);
    tick();
    chk("lock_step2", state_out, 8'hFF);
`endif
    enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    limit = 8'd1;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("mid_gen_state", state_out, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 8'(valid), 8'd0);
    chk("mid_rst_value", value, 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_state", state_out, 8'h00);
    tick();
    chk("mid_rst_valid_after", 8'(valid), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lfsr_rand.md
LFSR_RAND -- requirements
Module: lfsr_rand

Interface
REQ-001 Parameter WIDTH, default 8: LFSR state width, legal range 3..32.
REQ-002 Parameter TAPS, default 8'h88: feedback tap mask over state bits; the default selects bits 7 and 3.
REQ-003 Parameter OUT_W, default 8: result width; SHALL be <= WIDTH.
REQ-004 Parameter MAX_TRIES, default 4: maximum rejection steps per request, legal range 1..255.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  free-run step enable while IDLE.
REQ-008 seed_load  in  1  load seed into LFSR at next edge.
REQ-009 seed  in  WIDTH  seed value.
REQ-010 req  in  1  request one bounded random value; sampled only in IDLE.
REQ-011 limit  in  OUT_W  exclusive upper bound of the result, latched with req.
REQ-012 busy  out  1  high while in state GEN.
REQ-013 valid  out  1  one-cycle pulse when value is updated.
REQ-014 value  out  OUT_W  last result, held until the next valid.
REQ-015 state_out  out  WIDTH  current LFSR state.

Function
REQ-016 Step SHALL be next = {state[WIDTH-2:0], fb}, where fb = XNOR-reduce(state & TAPS); the all-ones state is the lock-up state.
REQ-017 FSM states SHALL be IDLE and GEN.
- IDLE: step when enable=1; req=1 latches limit, clears the try counter, and moves to GEN.
- GEN: step every edge regardless of enable.
REQ-018 In GEN, the candidate SHALL be the low OUT_W bits of the stepped state.
- If candidate < limit: value <= candidate, valid=1, go to IDLE.
- Else: increment the try counter.
REQ-019 When the try counter reaches MAX_TRIES without acceptance, the block SHALL set value <= limit-1, pulse valid, and go to IDLE.
REQ-020 If limit==0, the block SHALL set value <= 0 at the first GEN edge (one step consumed), pulse valid, and go to IDLE.
REQ-021 Minimum latency SHALL be 2 edges: req is sampled at edge N, and valid is high in the cycle after edge N+1.
REQ-022 seed_load SHALL take priority over stepping and req.
- In GEN, seed_load aborts the request: no valid, return to IDLE.
REQ-023 req asserted while busy=1 SHALL be ignored; there is no queueing.
REQ-024 Changes to limit during GEN SHALL have no effect.

Reset
REQ-025 reset SHALL force: state=0, FSM=IDLE, try counter=0, busy=0, valid=0, value=0.
REQ-026 reset asserted mid-GEN SHALL abort the request with no valid.

Configuration
REQ-027 With LFSR_RAND_LOCKUP_RECOVER_EN defined: a loaded seed of all-ones, or an all-ones state reached any other way, SHALL be replaced by 0 at the next edge.
REQ-028 Without LFSR_RAND_LOCKUP_RECOVER_EN: an all-ones state SHALL persist; every step yields all-ones.

Structure
REQ-029 Package lfsr_rand_pkg SHALL hold the FSM state enum and the named default tap-mask constants for widths 8, 16 and 32.
REQ-030 Sub-module lfsr_core SHALL contain the state register, step, seed load and lock-up recovery; lfsr_rand holds the FSM, try counter and output registers.

Verification (defaults: WIDTH=8, TAPS=8'h88, OUT_W=8, MAX_TRIES=4)
REQ-031 Free-run: reset, then enable=1 for 5 edges -> state_out 01, 03, 07, 0F, 1E.
REQ-032 Accept: after reset, enable=0, limit=4, req pulse -> busy for 1 cycle, then valid with value=01 two edges after req.
REQ-033 Fallback: after reset, limit=1, req -> candidates 01, 03, 07, 0F are all rejected; valid with value=00 after the 4th GEN edge; state_out=0F.
REQ-034 Abort: req, then seed_load=1 with seed=5A on the next edge -> no valid, FSM returns to IDLE, state_out=5A.
REQ-035 Lock-up: seed_load with seed=FF, then enable=1 -> state_out becomes 00 then 01 with the macro defined; stays FF without it.
REQ-036 Reset mid-GEN: limit=1, req, reset asserted at the 2nd GEN edge -> no valid, value=00, busy=0, state_out=00.
